// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared widths, opcodes and FSM states for the ALU arbiter
package alu_arbiter_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
  localparam int ALU_OPRN_WIDTH       = 6;
  localparam int ALU_OPRN_INDEX_LIMIT = ALU_OPRN_WIDTH - 1;

  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_ADD = 6'h20;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SUB = 6'h22;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_MUL = 6'h2c;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SRL = 6'h02;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SLL = 6'h01;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_AND = 6'h24;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_OR  = 6'h25;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_NOR = 6'h27;
  localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SLT = 6'h2a;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_EXEC = 2'd1,
    ARB_ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit ALU shared by both requesters
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_INDEX_LIMIT:0]     op1,
  input  logic [DATA_INDEX_LIMIT:0]     op2,
  input  logic [ALU_OPRN_INDEX_LIMIT:0] oprn,
  output logic [DATA_INDEX_LIMIT:0]     out,
  output logic                          zero
);

  // Shifts of 32 or more flush every bit out, so they are forced to zero
  // rather than relying on the truncated shift amount.
  logic shift_flush;
  assign shift_flush = (op2 >= 32'(DATA_WIDTH));

  // Operation select; unknown opcodes give 0 so nothing downstream sees X.
  always_comb begin
    out = '0;
    case (oprn)
      ALU_OPRN_ADD: out = op1 + op2;
      ALU_OPRN_SUB: out = op1 - op2;
      ALU_OPRN_MUL: out = op1 * op2;
      ALU_OPRN_SRL: out = shift_flush ? '0 : (op1 >> op2[4:0]);
      ALU_OPRN_SLL: out = shift_flush ? '0 : (op1 << op2[4:0]);
      ALU_OPRN_AND: out = op1 & op2;
      ALU_OPRN_OR:  out = op1 | op2;
      ALU_OPRN_NOR: out = ~(op1 | op2);
      ALU_OPRN_SLT: out = {{DATA_INDEX_LIMIT{1'b0}}, (op1 < op2)};
      default:      out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port arbiter around a single registered ALU
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          REQ0_VALID,
  input  logic [DATA_INDEX_LIMIT:0]     REQ0_OP1,
  input  logic [DATA_INDEX_LIMIT:0]     REQ0_OP2,
  input  logic [ALU_OPRN_INDEX_LIMIT:0] REQ0_OPRN,
  output logic                          REQ0_READY,
  input  logic                          REQ1_VALID,
  input  logic [DATA_INDEX_LIMIT:0]     REQ1_OP1,
  input  logic [DATA_INDEX_LIMIT:0]     REQ1_OP2,
  input  logic [ALU_OPRN_INDEX_LIMIT:0] REQ1_OPRN,
  output logic                          REQ1_READY,
  output logic                          RES0_VALID,
  input  logic                          RES0_ACK,
  output logic                          RES1_VALID,
  input  logic                          RES1_ACK,
  output logic [DATA_INDEX_LIMIT:0]     RES,
  output logic                          ZERO,
  output logic                          ERR,
  output logic                          BUSY
);

  arb_state_t state, state_nx;

  logic                          last_grant;
  logic                          grant_vld;
  logic                          grant_id;
  logic                          xfer;
  logic                          ack_sel;
  logic                          oprn_ok;

  logic [DATA_INDEX_LIMIT:0]     op1_q;
  logic [DATA_INDEX_LIMIT:0]     op2_q;
  logic [ALU_OPRN_INDEX_LIMIT:0] oprn_q;
  logic                          id_q;

  logic [DATA_INDEX_LIMIT:0]     alu_out;
  logic                          alu_zero;

  // Round-robin pick: a lone requester wins outright, a tie goes to the
  // port that was not served last.
  always_comb begin
    grant_vld = REQ0_VALID | REQ1_VALID;
    grant_id  = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = REQ1_VALID;
    end
  end

  assign REQ0_READY = (state == ARB_ST_IDLE) & grant_vld & ~grant_id;
  assign REQ1_READY = (state == ARB_ST_IDLE) & grant_vld &  grant_id;
  assign xfer       = REQ0_READY | REQ1_READY;
  assign ack_sel    = id_q ? RES1_ACK : RES0_ACK;

  // Opcode validity decode on the latched opcode, used to override the ALU.
  always_comb begin
    oprn_ok = 1'b0;
    case (oprn_q)
      ALU_OPRN_ADD, ALU_OPRN_SUB, ALU_OPRN_MUL,
      ALU_OPRN_SRL, ALU_OPRN_SLL, ALU_OPRN_AND,
      ALU_OPRN_OR,  ALU_OPRN_NOR, ALU_OPRN_SLT: oprn_ok = 1'b1;
      default:                                  oprn_ok = 1'b0;
    endcase
  end

  // The ALU only ever sees the latched operands, so its inputs are stable
  // for the whole EXEC cycle.
  alu_arbiter_alu alu_inst_01 (
    .op1  (op1_q),
    .op2  (op2_q),
    .oprn (oprn_q),
    .out  (alu_out),
    .zero (alu_zero)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ARB_ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: one operation in flight, held in RESP until its owner acks.
  always_comb begin
    state_nx = state;
    case (state)
      ARB_ST_IDLE: if (xfer) state_nx = ARB_ST_EXEC;
      ARB_ST_EXEC: state_nx = ARB_ST_RESP;
      ARB_ST_RESP: if (ack_sel) state_nx = ARB_ST_IDLE;
      default:     state_nx = ARB_ST_IDLE;
    endcase
  end

  // Operand capture on accept, result capture at the end of EXEC, and the
  // round-robin pointer update once the response has been consumed.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      op1_q      <= '0;
      op2_q      <= '0;
      oprn_q     <= '0;
      id_q       <= 1'b0;
      RES        <= '0;
      ZERO       <= 1'b0;
      ERR        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ARB_ST_IDLE: begin
          if (xfer) begin
            op1_q  <= REQ1_READY ? REQ1_OP1  : REQ0_OP1;
            op2_q  <= REQ1_READY ? REQ1_OP2  : REQ0_OP2;
            oprn_q <= REQ1_READY ? REQ1_OPRN : REQ0_OPRN;
            id_q   <= REQ1_READY;
          end
        end
        ARB_ST_EXEC: begin
          if (oprn_ok) begin
            RES  <= alu_out;
            ZERO <= alu_zero;
            ERR  <= 1'b0;
          end else begin
            RES  <= '0;
            ZERO <= 1'b1;
            ERR  <= 1'b1;
          end
        end
        ARB_ST_RESP: begin
          if (ack_sel) last_grant <= id_q;
        end
        default: ;
      endcase
    end
  end

  // Status outputs come straight from the state and id flops.
  assign RES0_VALID = (state == ARB_ST_RESP) & ~id_q;
  assign RES1_VALID = (state == ARB_ST_RESP) &  id_q;
  assign BUSY       = (state != ARB_ST_IDLE);

endmodule
